// File: rtl/mul_arbiter.sv
// mul_arbiter: two-port arbiter sharing one external 8x8 multiplier.
//
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   req0, req1       operation requests, held until the matching grant
//   a0, b0, a1, b1   8-bit operands per port (passed through unmodified)
//   gnt0, gnt1       one-cycle pulse; operands of that port were captured on this edge
//   vld0, vld1       one-cycle pulse; result of that port is valid
//   res0, res1       16-bit result per port, held until that port's next completion
//   err              qualifies the vld pulse; high = watchdog abort
//   busy             high in every state except IDLE
//   mult_start       one-cycle start pulse to the shared multiplier
//   mult_a, mult_b   multiplier operands, stable from ISSUE through WAIT
//   mult_done        multiplier completion (0->1 transition in WAIT counts)
//   mult_res         multiplier product
//
// Parameter WD_MAX: number of WAIT cycles before the watchdog aborts (6-bit counter).
// Macro MUL_ARB_RR_EN: when defined, ties go to the port not served last;
// otherwise port 0 always wins ties and no pointer register exists.
module mul_arbiter #(
    parameter int WD_MAX = 63
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        vld0,
    output logic        vld1,
    output logic [15:0] res0,
    output logic [15:0] res1,
    output logic        err,
    output logic        busy,
    output logic        mult_start,
    output logic [7:0]  mult_a,
    output logic [7:0]  mult_b,
    input  logic        mult_done,
    input  logic [15:0] mult_res
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        sel_q, sel_d;
    logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [7:0]  ma_q, ma_d, mb_q, mb_d;
    logic [15:0] res0_q, res0_d, res1_q, res1_d;
    logic        err_q, err_d;
    logic [5:0]  wd_q, wd_d;
    logic        done_q;
    logic        win;
    logic        done_rise;

`ifdef MUL_ARB_RR_EN
    logic last_q, last_d;
    // on a tie the port not served last wins; a lone request always wins
    assign win = (req0 && req1) ? ~last_q : req1;
`else
    assign win = ~req0;
`endif

    // only a fresh edge completes, so a level already high on WAIT entry is ignored
    assign done_rise = mult_done && !done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ma_q    <= 8'h00;
            mb_q    <= 8'h00;
            res0_q  <= 16'h0000;
            res1_q  <= 16'h0000;
            err_q   <= 1'b0;
            wd_q    <= 6'd0;
            done_q  <= 1'b0;
`ifdef MUL_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            done_q  <= mult_done;
`ifdef MUL_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ma_d    = ma_q;
        mb_d    = mb_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        err_d   = err_q;
        wd_d    = wd_q;
`ifdef MUL_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    sel_d   = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    ma_d    = win ? a1 : a0;
                    mb_d    = win ? b1 : b0;
`ifdef MUL_ARB_RR_EN
                    last_d  = win;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = 6'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (done_rise) begin
                    res0_d  = sel_q ? res0_q : mult_res;
                    res1_d  = sel_q ? mult_res : res1_q;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wd_q == 6'(WD_MAX - 1)) begin
                    res0_d  = sel_q ? res0_q : 16'h0000;
                    res1_d  = sel_q ? 16'h0000 : res1_q;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wd_d    = wd_q + 6'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign vld0       = (state_q == RESP) && !sel_q;
    assign vld1       = (state_q == RESP) && sel_q;
    assign res0       = res0_q;
    assign res1       = res1_q;
    assign err        = err_q;
    assign busy       = state_q != IDLE;
    assign mult_start = state_q == ISSUE;
    assign mult_a     = ma_q;
    assign mult_b     = mb_q;
endmodule
